// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file address and write-enable types
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0] reg_onehot_t;
endpackage

// File: rtl/decoder_5_32.sv
// decoder_5_32: register address to one-hot register select
module decoder_5_32
    import rf_pkg::*;
(
    input  reg_addr_t   i_addr,
    output reg_onehot_t o_onehot
);
    assign o_onehot = reg_onehot_t'(1) << i_addr;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port with a busy scoreboard
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  reg_addr_t         req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  reg_addr_t         req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  reg_addr_t         rsv_rd,
    output reg_onehot_t       wr_we,
    output reg_addr_t         wr_addr,
    output logic [XLEN-1:0]   wr_data,
    output reg_onehot_t       busy,
    output logic [CNT_W-1:0]  conflict_cnt
);
    logic             r_rr_ptr;
    reg_onehot_t      r_wr_we;
    reg_addr_t        r_wr_addr;
    logic [XLEN-1:0]  r_wr_data;
    reg_onehot_t      r_busy;
    logic [CNT_W-1:0] r_conflict_cnt;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant;
    reg_addr_t        w_rd;
    logic [XLEN-1:0]  w_data;
    reg_onehot_t      w_dec;
    reg_onehot_t      w_set;
    reg_onehot_t      w_clr;

    assign w_grant0 = req0_valid && (!req1_valid || !r_rr_ptr);
    assign w_grant1 = req1_valid && (!req0_valid || r_rr_ptr);
    assign w_grant = w_grant0 || w_grant1;
    assign w_rd = w_grant1 ? req1_rd : req0_rd;
    assign w_data = w_grant1 ? req1_data : req0_data;
    assign req0_ready = rst_n && w_grant0;
    assign req1_ready = rst_n && w_grant1;
    // x0 reservations are dropped so busy[0] can never be set
    assign w_set = (rsv_valid && rsv_rd != '0) ? (reg_onehot_t'(1) << rsv_rd) : '0;
    assign w_clr = w_grant1 ? (reg_onehot_t'(1) << req1_rd) : '0;

    decoder_5_32 u_dec (
        .i_addr  (w_rd),
        .o_onehot(w_dec)
    );

    // Register the winning write and hand the round-robin turn to the loser
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= 1'b0;
            r_wr_we   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_we <= (w_grant && w_rd != '0) ? w_dec : '0;
            if (w_grant) begin
                r_rr_ptr  <= w_grant0;
                r_wr_addr <= w_rd;
                r_wr_data <= w_data;
            end
        end
    end

    // Track registers awaiting a requester-1 write; a same-cycle set beats the clear
    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else r_busy <= (r_busy & ~w_clr) | w_set;
    end

    // Count contention cycles, sticking at the top value
    always_ff @(posedge clk) begin
        if (!rst_n) r_conflict_cnt <= '0;
        else if (req0_valid && req1_valid && r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end

    assign wr_we = r_wr_we;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy = r_busy;
    assign conflict_cnt = r_conflict_cnt;

    a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_rd) && $stable(req0_data)));
    a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_rd) && $stable(req1_data)));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector bench for the write-port arbiter
module tb_regfile_write_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsv_valid;
    reg_addr_t   req0_rd, req1_rd, rsv_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    reg_onehot_t wr_we, busy;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    logic [15:0] conflict_cnt;
    logic        s_r0, s_r1;
    reg_onehot_t s_we, s_busy;
    reg_addr_t   s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .conflict_cnt(conflict_cnt)
    );

    regfile_write_arbiter #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(s_r1),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .wr_we(s_we), .wr_addr(s_addr), .wr_data(s_data), .busy(s_busy), .conflict_cnt(s_cnt)
    );

    typedef struct {
        logic        v0;
        reg_addr_t   rd0;
        logic [31:0] d0;
        logic        v1;
        reg_addr_t   rd1;
        logic [31:0] d1;
        logic        sv;
        reg_addr_t   srd;
        logic        e_r0;
        logic        e_r1;
        logic [31:0] e_we;
        reg_addr_t   e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        logic [15:0] e_cnt;
        logic [1:0]  e_sat;
    } vec_t;

    vec_t tv[15];

    function automatic vec_t mk(
        input logic v0, input reg_addr_t rd0, input logic [31:0] d0,
        input logic v1, input reg_addr_t rd1, input logic [31:0] d1,
        input logic sv, input reg_addr_t srd,
        input logic e_r0, input logic e_r1, input logic [31:0] e_we, input reg_addr_t e_addr,
        input logic [31:0] e_data, input logic [31:0] e_busy, input logic [15:0] e_cnt, input logic [1:0] e_sat);
        vec_t v;
        v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1; v.sv = sv; v.srd = srd;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
        v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_sat = e_sat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input reg_addr_t rd0, input logic [31:0] d0,
                         input logic v1, input reg_addr_t rd1, input logic [31:0] d1,
                         input logic sv, input reg_addr_t srd);
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
        rsv_valid = sv; rsv_rd = srd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h20, 5'd5, 32'hDEADBEEF, 32'h0, 16'd0, 2'd0);
        tv[1]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd5, 32'hDEADBEEF, 32'h0, 16'd0, 2'd0);
        tv[2]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1, 32'h8, 5'd3, 32'h33, 32'h0, 16'd0, 2'd0);
        tv[3]  = mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 1'b0, 32'h2, 5'd1, 32'h11, 32'h0, 16'd1, 2'd1);
        tv[4]  = mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 1'b1, 32'h4, 5'd2, 32'h22, 32'h0, 16'd2, 2'd2);
        tv[5]  = mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 1'b0, 32'h2, 5'd1, 32'h11, 32'h0, 16'd3, 2'd3);
        tv[6]  = mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 1'b1, 32'h4, 5'd2, 32'h22, 32'h0, 16'd4, 2'd3);
        tv[7]  = mk(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h2, 5'd1, 32'h11, 32'h0, 16'd4, 2'd3);
        tv[8]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0, 5'd0, 32'h1234, 32'h0, 16'd4, 2'd3);
        tv[9]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0, 5'd0, 32'h1234, 32'h80, 16'd4, 2'd3);
        tv[10] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b0, 1'b1, 32'h80, 5'd7, 32'h77, 32'h80, 16'd4, 2'd3);
        tv[11] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 1'b0, 1'b1, 32'h80, 5'd7, 32'h78, 32'h0, 16'd4, 2'd3);
        tv[12] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 5'd7, 32'h78, 32'h0, 16'd4, 2'd3);
        tv[13] = mk(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, 32'h200, 5'd9, 32'h99, 32'h200, 16'd4, 2'd3);
        tv[14] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd4, 1'b0, 1'b1, 32'h200, 5'd9, 32'hAA, 32'h10, 16'd4, 2'd3);

        rst_n = 1'b0;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rst%0d_r0", c), 32'(req0_ready), 32'h0);
            chk($sformatf("rst%0d_r1", c), 32'(req1_ready), 32'h0);
            tick();
        end
        chk("rst_we", wr_we, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        chk("post_rst_we", wr_we, 32'h0);
        chk("post_rst_addr", 32'(wr_addr), 32'h0);
        chk("post_rst_data", wr_data, 32'h0);
        chk("post_rst_busy", busy, 32'h0);
        chk("post_rst_cnt", 32'(conflict_cnt), 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive(tv[i].v0, tv[i].rd0, tv[i].d0, tv[i].v1, tv[i].rd1, tv[i].d1, tv[i].sv, tv[i].srd);
            #1;
            chk($sformatf("v%0d_r0", i), 32'(req0_ready), 32'(tv[i].e_r0));
            chk($sformatf("v%0d_r1", i), 32'(req1_ready), 32'(tv[i].e_r1));
            tick();
            chk($sformatf("v%0d_we", i), wr_we, tv[i].e_we);
            chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(tv[i].e_addr));
            chk($sformatf("v%0d_data", i), wr_data, tv[i].e_data);
            chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(tv[i].e_cnt));
            chk($sformatf("v%0d_sat", i), 32'(s_cnt), 32'(tv[i].e_sat));
        end

        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        chk("mid_rst_r0", 32'(req0_ready), 32'h0);
        tick();
        chk("mid_rst_we", wr_we, 32'h0);
        chk("mid_rst_busy", busy, 32'h0);
        chk("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
        chk("mid_rst_sat", 32'(s_cnt), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        chk("mid_rst_we2", wr_we, 32'h0);

        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk($sformatf("sat%0d_r0", i), 32'(s_r0), 32'(i % 2));
            chk($sformatf("sat%0d_r1", i), 32'(s_r1), 32'((i + 1) % 2));
            tick();
            chk($sformatf("sat%0d_we", i), s_we, (i % 2 == 1) ? 32'h2 : 32'h4);
            chk($sformatf("sat%0d_cnt", i), 32'(conflict_cnt), 32'(i));
            chk($sformatf("sat%0d_sat", i), 32'(s_cnt), (i < 3) ? 32'(i) : 32'd3);
        end
        drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        chk("sat_tail_r0", 32'(s_r0), 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        chk("sat_tail_cnt", 32'(conflict_cnt), 32'd6);
        chk("sat_tail_sat", 32'(s_cnt), 32'd3);
        chk("sat_tail_addr", 32'(s_addr), 32'd1);
        chk("sat_tail_data", s_data, 32'h11);
        chk("sat_tail_busy", s_busy, 32'h0);
        chk("sat_tail_we", s_we, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
